// File: rtl/filter_tap_loader_pkg.sv
// Shared definitions for the filter tap-setting message transmitter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Holds the default message width (`MSG_WIDTH), header field layout,
// the clog2 helper and the loader FSM encoding.

`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

package filter_tap_loader_pkg;

  localparam int MSG_WIDTH_DEF = `MSG_WIDTH;

  // Header flag sits in the top bit of the message word.
  localparam int HDR_FLAG_POS = MSG_WIDTH_DEF - 1;

  // Header field offsets: destination ID in [7:0], tap count in [15:8].
  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_ID_W    = 8;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_LEN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TAPS = 2'd2,
    ST_CSUM = 2'd3
  } state_e;

  // Header flag position for an arbitrary message width.
  function automatic int msg_flag_pos(input int msg_w);
    return msg_w - 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/filter_tap_bank.sv
// Shadow/active tap register bank with snapshot-on-load and out-of-range write detect.
// Latency: writes and snapshots land on the next clk edge; read by index is combinational.
// Backpressure: none; writes are always accepted, out-of-range ones are dropped and flagged.
//
// Ports:
//   clk       clock
//   wr_vld    write strobe;  wr_addr / wr_dat  index and signed tap value
//   wr_err    combinational: current write strobe targets an index >= FLTLEN
//   load      copy shadow -> active on this edge (pre-write shadow contents)
//   rd_idx    active-bank read index;  rd_dat  combinational read data

module filter_tap_bank #(
  parameter int TAPWIDTH   = 16,
  parameter int FLTLEN     = 10,
  parameter int LOG_FLTLEN = 4
) (
  input  logic                       clk,
  input  logic                       wr_vld,
  input  logic [LOG_FLTLEN-1:0]      wr_addr,
  input  logic signed [TAPWIDTH-1:0] wr_dat,
  output logic                       wr_err,
  input  logic                       load,
  input  logic [LOG_FLTLEN-1:0]      rd_idx,
  output logic signed [TAPWIDTH-1:0] rd_dat
);

  logic signed [TAPWIDTH-1:0] shadow_q [FLTLEN];
  logic signed [TAPWIDTH-1:0] shadow_d [FLTLEN];
  logic signed [TAPWIDTH-1:0] active_q [FLTLEN];
  logic signed [TAPWIDTH-1:0] active_d [FLTLEN];
  logic                       addr_ok;

  assign addr_ok = (32'(wr_addr) < FLTLEN);
  assign wr_err  = wr_vld && !addr_ok;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_vld && addr_ok) shadow_d[wr_addr] = wr_dat;
    // Snapshot reads shadow_q, so a write in the same cycle is not captured.
    if (load) active_d = shadow_q;
  end

  // Tap storage carries no reset; contents are defined once the host writes them.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    active_q <= active_d;
  end

  assign rd_dat = active_q[rd_idx];

endmodule

// File: rtl/filter_tap_loader.sv
// Transmit end of the tap-setting protocol: snapshots the shadow bank and sends header + taps.
// Latency: header one cycle after an accepted start, then one tap word per cycle.
// Backpressure: none on the bus; starts while busy are dropped and set the sticky error.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_tap_we/addr/data   shadow-bank write port (accepted in every state)
//   in_start              request transmission of the current shadow bank
//   out_msg, out_msg_nd   message word and its valid strobe (word is 0 when not valid)
//   busy                  message in progress;  done  pulse with the final word
//   error                 sticky: out-of-range write or start while not idle
// Optional build macro FILTER_TAP_LOADER_CHECKSUM_EN appends a checksum word.

module filter_tap_loader
  import filter_tap_loader_pkg::*;
#(
  parameter int TAPWIDTH  = 16,
  parameter int FLTLEN    = 10,
  parameter int DEST_ID   = 0,
  parameter int MSG_WIDTH = MSG_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_tap_we,
  input  logic [clog2(FLTLEN)-1:0]     in_tap_addr,
  input  logic signed [TAPWIDTH-1:0]   in_tap_data,
  input  logic                         in_start,
  output logic [MSG_WIDTH-1:0]         out_msg,
  output logic                         out_msg_nd,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int LOG_FLTLEN = clog2(FLTLEN);
  localparam int FLAG_POS   = msg_flag_pos(MSG_WIDTH);
  localparam logic [LOG_FLTLEN-1:0] LAST_IDX = LOG_FLTLEN'(FLTLEN - 1);

  state_e                     state_q, state_d;
  logic [LOG_FLTLEN-1:0]      cnt_q, cnt_d;
  logic [MSG_WIDTH-1:0]       out_msg_q, out_msg_d;
  logic                       out_msg_nd_q, out_msg_nd_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                       load;
  logic                       emit_tap;
  logic                       wr_err;
  logic signed [TAPWIDTH-1:0] tap_rd;
  logic signed [MSG_WIDTH-2:0] tap_ext;
  logic [MSG_WIDTH-1:0]       hdr_word;

  filter_tap_bank #(
    .TAPWIDTH   (TAPWIDTH),
    .FLTLEN     (FLTLEN),
    .LOG_FLTLEN (LOG_FLTLEN)
  ) u_bank (
    .clk     (clk),
    .wr_vld  (in_tap_we),
    .wr_addr (in_tap_addr),
    .wr_dat  (in_tap_data),
    .wr_err  (wr_err),
    .load    (load),
    .rd_idx  (cnt_d),
    .rd_dat  (tap_rd)
  );

  // Signed size cast sign-extends the tap into the payload field.
  assign tap_ext = (MSG_WIDTH-1)'(tap_rd);

  always_comb begin
    hdr_word = '0;
    hdr_word[FLAG_POS] = 1'b1;
    hdr_word[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(FLTLEN);
    hdr_word[HDR_ID_LSB +: HDR_ID_W]   = HDR_ID_W'(DEST_ID);
  end

`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
  logic [MSG_WIDTH-2:0] csum_q, csum_d;
`endif

  // The output registers hold the word that is on the bus while state_q is
  // in the matching state, so next-word selection keys off state_d/cnt_d.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_msg_d    = '0;
    out_msg_nd_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;
    emit_tap     = 1'b0;
    error_d      = error_q | wr_err;

    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          load         = 1'b1;
          state_d      = ST_HDR;
          cnt_d        = '0;
          out_msg_d    = hdr_word;
          out_msg_nd_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_HDR: begin
        state_d  = ST_TAPS;
        cnt_d    = '0;
        emit_tap = 1'b1;
      end
      ST_TAPS: begin
        if (cnt_q == LAST_IDX) begin
`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
          state_d      = ST_CSUM;
          out_msg_d    = {1'b0, csum_q};
          out_msg_nd_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b1;
`else
          state_d      = ST_IDLE;
`endif
        end else begin
          cnt_d    = cnt_q + 1'b1;
          emit_tap = 1'b1;
        end
      end
      ST_CSUM: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_start && (state_q != ST_IDLE)) error_d = 1'b1;

    if (emit_tap) begin
      out_msg_d    = {1'b0, tap_ext};
      out_msg_nd_d = 1'b1;
      busy_d       = 1'b1;
`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
      done_d       = 1'b0;
`else
      done_d       = (cnt_d == LAST_IDX);
`endif
    end
  end

`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
  // Running sum of the sign-extended taps as they are sent.
  always_comb begin
    csum_d = csum_q;
    if (load)     csum_d = '0;
    if (emit_tap) csum_d = csum_q + tap_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_msg_q    <= '0;
      out_msg_nd_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_msg_q    <= out_msg_d;
      out_msg_nd_q <= out_msg_nd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign out_msg    = out_msg_q;
  assign out_msg_nd = out_msg_nd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_filter_tap_loader.sv
// Self-checking bench for filter_tap_loader (FLTLEN=10, DEST_ID=3, TAPWIDTH=16, MSG_WIDTH=32).
// Expected words are pushed to a scoreboard queue when a start is driven and
// popped by a monitor on the falling edge whenever out_msg_nd is high.

module tb_filter_tap_loader;

  localparam int TW   = 16;
  localparam int LEN  = 10;
  localparam int DID  = 3;
  localparam int MW   = 32;
`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
  localparam int EXP_BUSY = LEN + 2;
`else
  localparam int EXP_BUSY = LEN + 1;
`endif
  localparam logic [31:0] HDR = 32'h8000_0A03;

  logic          clk;
  logic          rst;
  logic          in_tap_we;
  logic [3:0]    in_tap_addr;
  logic [TW-1:0] in_tap_data;
  logic          in_start;
  logic [MW-1:0] out_msg;
  logic          out_msg_nd;
  logic          busy;
  logic          done;
  logic          error;

  filter_tap_loader #(
    .TAPWIDTH  (TW),
    .FLTLEN    (LEN),
    .DEST_ID   (DID),
    .MSG_WIDTH (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_tap_we   (in_tap_we),
    .in_tap_addr (in_tap_addr),
    .in_tap_data (in_tap_data),
    .in_start    (in_start),
    .out_msg     (out_msg),
    .out_msg_nd  (out_msg_nd),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        d;
  } exp_t;

  exp_t          sb_q[$];
  logic [TW-1:0] model[LEN];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (out_msg_nd === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", out_msg, 32'hDEAD_BEEF);
      end else begin
        e = sb_q.pop_front();
        check("msg_word", out_msg, e.w);
        check("done_flag", {31'd0, done}, {31'd0, e.d});
      end
    end else begin
      check("quiet_bus", {out_msg[30:0], done}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [TW-1:0] d);
    in_tap_we   = 1'b1;
    in_tap_addr = a;
    in_tap_data = d;
    if (a < LEN) model[a] = d;
    tick();
    in_tap_we = 1'b0;
  endtask

  // Pushes the message for the current model snapshot, then pulses start,
  // optionally with a same-cycle write (applied to the model after the snapshot).
  task automatic start_msg(input bit with_wr, input logic [3:0] a, input logic [TW-1:0] d);
    exp_t e;
    int   sum;
    sum = 0;
    e.w = HDR;
    e.d = 1'b0;
    sb_q.push_back(e);
    for (int k = 0; k < LEN; k++) begin
      e.w = {1'b0, {(MW-1-TW){model[k][TW-1]}}, model[k]};
      sum = sum + int'($signed(model[k]));
`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
      e.d = 1'b0;
`else
      e.d = (k == LEN - 1);
`endif
      sb_q.push_back(e);
    end
`ifdef FILTER_TAP_LOADER_CHECKSUM_EN
    e.w = {1'b0, sum[30:0]};
    e.d = 1'b1;
    sb_q.push_back(e);
`endif
    in_start = 1'b1;
    if (with_wr) begin
      in_tap_we   = 1'b1;
      in_tap_addr = a;
      in_tap_data = d;
      if (a < LEN) model[a] = d;
    end
    tick();
    in_start  = 1'b0;
    in_tap_we = 1'b0;
  endtask

  // Checks header latency, busy length and that the whole message arrived.
  // inject>0: at that busy cycle pulse a stray start plus an out-of-range write.
  task automatic finish_msg(input string tag, input int inject);
    int cnt;
    cnt = 0;
    @(negedge clk);
    check({tag, "_hdr_latency"}, {31'd0, out_msg_nd}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (cnt == inject) begin
        in_start    = 1'b1;
        in_tap_we   = 1'b1;
        in_tap_addr = 4'd12;
        in_tap_data = 16'h7777;
        tick();
        in_start  = 1'b0;
        in_tap_we = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_len"}, cnt, EXP_BUSY);
    check({tag, "_drained"}, sb_q.size(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    in_tap_we   = 1'b0;
    in_tap_addr = '0;
    in_tap_data = '0;
    in_start    = 1'b0;
    for (int i = 0; i < LEN; i++) model[i] = '0;
    tick(); tick(); tick();

    @(negedge clk);
    check("rst_out_msg", out_msg, 32'd0);
    check("rst_nd", {31'd0, out_msg_nd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    tick();

    // Taps 1..10.
    for (int i = 0; i < LEN; i++) wr(4'(i), 16'(i + 1));
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("ramp", 0);

    // Negative extremes: -1 and most-negative.
    wr(4'd0, 16'hFFFF);
    wr(4'd9, 16'h8000);
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("sign", 0);

    // Write in the start cycle must not affect the snapshot.
    wr(4'd0, 16'h0011);
    start_msg(1'b1, 4'd0, 16'h0055);
    finish_msg("snap_pre", 0);
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("snap_post", 0);
    check("error_clean", {31'd0, error}, 32'd0);

    // Stray start during TAPS and an out-of-range write.
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("err_msg", 5);
    check("error_set", {31'd0, error}, 32'd1);
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("err_after", 0);
    check("error_sticky", {31'd0, error}, 32'd1);

    // Reset while tap 4 is on the bus.
    start_msg(1'b0, 4'd0, 16'd0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("mid_tap4_nd", {31'd0, out_msg_nd}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_nd", {31'd0, out_msg_nd}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    start_msg(1'b0, 4'd0, 16'd0);
    finish_msg("post_rst", 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
